// File: rtl/hdc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hdc_pkg : shared constants, state encoding and helpers for the HDC AM search |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package hdc_pkg;

  localparam int NUM_CLASSES = 26;
  localparam int CHUNK_W     = 64;
  localparam int NUM_CHUNKS  = 80;
  localparam int SIM_W       = 13;
  localparam int CLASS_W     = 5;
  localparam int AM_ADDR_W   = 12;
  localparam int Q_ADDR_W    = 7;
  localparam int POP_W       = 7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_Q = 3'd1,
    S_SCAN   = 3'd2,
    S_DRAIN  = 3'd3,
    S_INFER  = 3'd4,
    S_DONE   = 3'd5
  } am_search_state_t;

  // Saturating accumulate; the extra sum bit flags overflow.
  function automatic logic [SIM_W-1:0] sat_add(input logic [SIM_W-1:0] acc,
                                               input logic [POP_W-1:0] inc);
    logic [SIM_W:0] sum;
    sum = {1'b0, acc} + {{(SIM_W + 1 - POP_W){1'b0}}, inc};
    return sum[SIM_W] ? {SIM_W{1'b1}} : sum[SIM_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/am_search_ctrl_popcount.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | am_overlap_popcount : number of bit positions set in both input words      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module am_overlap_popcount
  import hdc_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  output logic [POP_W-1:0]   count
);

  logic [CHUNK_W-1:0] w_overlap;

  assign w_overlap = a & b;

  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      count = count + POP_W'(w_overlap[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/am_search_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | am_search_ctrl : streams query and class hypervectors, accumulates overlap |
// | per class, triggers the external argmax and returns the winning class.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module am_search_ctrl
  import hdc_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 nrst,
  input  logic                                 start_valid,
  output logic                                 start_ready,
  input  logic                                 abort,
  output logic                                 q_rd_en,
  output logic [Q_ADDR_W-1:0]                  q_rd_addr,
  input  logic [CHUNK_W-1:0]                   q_rd_data,
  output logic                                 am_rd_en,
  output logic [AM_ADDR_W-1:0]                 am_rd_addr,
  input  logic [CHUNK_W-1:0]                   am_rd_data,
  output logic [NUM_CLASSES-1:0][SIM_W-1:0]    similarity_values,
  output logic                                 inferring_class,
  input  logic [CLASS_W-1:0]                   class_inference,
  output logic                                 result_valid,
  input  logic                                 result_ready,
  output logic [CLASS_W-1:0]                   result_class,
  output logic                                 busy
);

  am_search_state_t                  r_state;
  am_search_state_t                  w_next;
  logic [Q_ADDR_W-1:0]               r_chunk;
  logic [CLASS_W-1:0]                r_class;
  logic [CLASS_W-1:0]                r_prev_class;
  logic                              r_am_pending;
  logic [CHUNK_W-1:0]                r_q;
  logic [NUM_CLASSES-1:0][SIM_W-1:0] r_sim;
  logic [CLASS_W-1:0]                r_result;
  logic [POP_W-1:0]                  w_pop;
  logic                              w_start;
  logic                              w_last_class;
  logic                              w_last_chunk;

  assign w_start      = start_valid && start_ready;
  assign w_last_class = (r_class == CLASS_W'(NUM_CLASSES - 1));
  assign w_last_chunk = (r_chunk == Q_ADDR_W'(NUM_CHUNKS - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_LOAD_Q;
      S_LOAD_Q: w_next = S_SCAN;
      S_SCAN:   if (w_last_class) w_next = w_last_chunk ? S_DRAIN : S_LOAD_Q;
      S_DRAIN:  w_next = S_INFER;
      S_INFER:  w_next = S_DONE;
      S_DONE:   if (result_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= S_IDLE;
      r_chunk      <= '0;
      r_class      <= '0;
      r_prev_class <= '0;
      r_am_pending <= 1'b0;
      r_q          <= '0;
      r_result     <= '0;
    end else begin
      r_state      <= w_next;
      // A read issued this cycle returns next cycle; abort discards it.
      r_am_pending <= (r_state == S_SCAN) && !abort;
      r_prev_class <= r_class;
      case (r_state)
        S_IDLE: if (w_start) r_chunk <= '0;
        S_LOAD_Q: r_class <= '0;
        S_SCAN: begin
          if (r_class == '0) r_q <= q_rd_data;
          if (!w_last_class) begin
            r_class <= r_class + CLASS_W'(1);
          end else if (!w_last_chunk) begin
            r_chunk <= r_chunk + Q_ADDR_W'(1);
          end
        end
        S_INFER: if (!abort) r_result <= class_inference;
        default: ;
      endcase
    end
  end

  am_overlap_popcount u_popcount (
    .a     (am_rd_data),
    .b     (r_q),
    .count (w_pop)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sim <= '0;
    end else if (w_start) begin
      r_sim <= '0;
    end else if (r_am_pending) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (r_prev_class == CLASS_W'(i)) r_sim[i] <= sat_add(r_sim[i], w_pop);
      end
    end
  end

  assign start_ready       = (r_state == S_IDLE) && !abort;
  assign busy              = (r_state != S_IDLE);
  assign q_rd_en           = (r_state == S_LOAD_Q);
  assign q_rd_addr         = q_rd_en ? r_chunk : '0;
  assign am_rd_en          = (r_state == S_SCAN);
  assign am_rd_addr        = am_rd_en ? (AM_ADDR_W'(r_class) * AM_ADDR_W'(NUM_CHUNKS)
                                         + AM_ADDR_W'(r_chunk)) : '0;
  assign inferring_class   = (r_state == S_INFER);
  assign result_valid      = (r_state == S_DONE);
  assign result_class      = r_result;
  assign similarity_values = r_sim;

endmodule
`default_nettype wire
